// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, controller
// states, configuration-target selectors and the power-on table contents.
package ucode_pkg;

   localparam logic [2:0] OP_NEXT  = 3'd0;
   localparam logic [2:0] OP_DISP1 = 3'd1;
   localparam logic [2:0] OP_DISP2 = 3'd2;
   localparam logic [2:0] OP_JUMP  = 3'd3;
   localparam logic [2:0] OP_HOME  = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } ctrl_state_e;

   localparam logic [1:0] SEL_UCODE = 2'd0;
   localparam logic [1:0] SEL_DROM1 = 2'd1;
   localparam logic [1:0] SEL_DROM2 = 2'd2;
   localparam logic [1:0] SEL_CTRL  = 2'd3;

   // Microcode image: 0..2 count up, 3 dispatches on DROM1, 4..6 jump,
   // 7..9 count up, 10 dispatches on DROM2, 11 and above return home.
   function automatic logic [2:0] defaultUcode(input logic [3:0] idx);
      logic [2:0] op;
      case (idx)
         4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd9: op = OP_NEXT;
         4'd3:                               op = OP_DISP1;
         4'd4, 4'd5, 4'd6:                   op = OP_JUMP;
         4'd10:                              op = OP_DISP2;
         default:                            op = OP_HOME;
      endcase
      return op;
   endfunction

   function automatic logic [3:0] defaultDrom1(input logic [1:0] idx);
      logic [3:0] tgt;
      case (idx)
         2'd0:    tgt = 4'd4;
         2'd1:    tgt = 4'd5;
         default: tgt = 4'd6;
      endcase
      return tgt;
   endfunction

   function automatic logic [3:0] defaultDrom2(input logic [1:0] idx);
      logic [3:0] tgt;
      case (idx)
         2'd0:    tgt = 4'd11;
         default: tgt = 4'd12;
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Brings the pushbutton and the 2-bit switch into the clock domain and
// latches the switch value into inp on each clean rising edge of the button.
// The switch goes through its own two flops so that the captured value has
// the same settling time as the button that qualifies it.
module btn_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_i,
   input  logic [1:0] y_i,
   output logic [1:0] inp_o
);

   logic       btnMeta_q;
   logic       btnSync_q;
   logic       btnPrev_q;
   logic [1:0] yMeta_q;
   logic [1:0] ySync_q;
   logic [1:0] inp_q;
   logic [1:0] inp_d;
   logic       btnRise;

   // Capture the synchronised switch only on a 0->1 transition of the button.
   always_comb begin
      btnRise = btnSync_q & ~btnPrev_q;
      inp_d   = btnRise ? ySync_q : inp_q;
   end

   // Synchroniser chains, edge-detect history and the latched input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btnMeta_q <= 1'b0;
         btnSync_q <= 1'b0;
         btnPrev_q <= 1'b0;
         yMeta_q   <= 2'd0;
         ySync_q   <= 2'd0;
         inp_q     <= 2'd0;
      end else begin
         btnMeta_q <= btn_i;
         btnSync_q <= btnMeta_q;
         btnPrev_q <= btnSync_q;
         yMeta_q   <= y_i;
         ySync_q   <= yMeta_q;
         inp_q     <= inp_d;
      end
   end

   assign inp_o = inp_q;

endmodule

// File: rtl/ucode_seq_ctrl.sv
// Run/step controller for the microcoded LED state machine. Holds the
// writable microcode store and both dispatch tables, paces free-running
// advances with a prescaler and parks in FAULT when an advance would land
// on an illegal opcode or an out-of-range state.
module ucode_seq_ctrl
   import ucode_pkg::*;
#(
   parameter int unsigned TICK_MAX = 100000000,
   parameter int unsigned NSTATES  = 13,
   parameter int unsigned JUMP_TGT = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic [1:0] y,
   input  logic       run,
   input  logic       step,
   input  logic       cfg_we,
   input  logic [1:0] cfg_sel,
   input  logic [3:0] cfg_addr,
   input  logic [3:0] cfg_data,
   output logic [3:0] state,
   output logic       tick,
   output logic       halted,
   output logic       fault,
   output logic       cfg_err
);

   localparam logic [31:0] TickLast   = 32'(TICK_MAX - 1);
   localparam logic [4:0]  StateLimit = 5'(NSTATES);
   localparam logic [3:0]  LastState  = 4'(NSTATES - 1);
   localparam logic [4:0]  JumpTarget = 5'(JUMP_TGT);

   ctrl_state_e ctrl_q, ctrl_d;
   logic [3:0]  state_q, state_d;
   logic [31:0] counter_q, counter_d;
   logic        fault_q, fault_d;
   logic        tick_q, tick_d;
   logic        cfgErr_q, cfgErr_d;

   logic [2:0]  ucode_q [16];
   logic [3:0]  drom1_q [4];
   logic [3:0]  drom2_q [4];
   logic        ucodeWe, drom1We, drom2We;

   logic [1:0]  inp;
   logic [2:0]  opcode;
   logic [4:0]  nextState;
   logic        advFault;
   logic        doAdvance;

   btn_sync uSync (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn),
      .y_i   (y),
      .inp_o (inp)
   );

   // Decode the current state's opcode into a candidate next state; the
   // sum is kept one bit wider so an out-of-range target is caught rather
   // than wrapping.
   always_comb begin
      opcode    = ucode_q[state_q];
      nextState = 5'd0;
      advFault  = 1'b0;
      case (opcode)
         OP_NEXT:  nextState = (state_q == LastState) ? 5'd0 : {1'b0, state_q} + 5'd1;
         OP_DISP1: nextState = {1'b0, drom1_q[inp]};
         OP_DISP2: nextState = {1'b0, drom2_q[inp]};
         OP_JUMP:  nextState = JumpTarget;
         OP_HOME:  nextState = 5'd0;
         default:  advFault  = 1'b1;
      endcase
      if (nextState >= StateLimit) begin
         advFault = 1'b1;
      end
   end

   // Controller next-state logic, advance handling and config-write checks.
   always_comb begin
      ctrl_d    = ctrl_q;
      state_d   = state_q;
      counter_d = counter_q;
      fault_d   = fault_q;
      tick_d    = 1'b0;
      cfgErr_d  = 1'b0;
      ucodeWe   = 1'b0;
      drom1We   = 1'b0;
      drom2We   = 1'b0;
      doAdvance = 1'b0;

      case (ctrl_q)
         IDLE: begin
            counter_d = 32'd0;
            if (run) begin
               ctrl_d = RUN;
            end else if (step) begin
               doAdvance = 1'b1;
            end
         end
         RUN: begin
            if (!run) begin
               ctrl_d    = IDLE;
               counter_d = 32'd0;
            end else if (counter_q == TickLast) begin
               doAdvance = 1'b1;
               counter_d = 32'd0;
            end else begin
               counter_d = counter_q + 32'd1;
            end
         end
         default: begin
            counter_d = 32'd0;
         end
      endcase

      if (doAdvance) begin
         if (advFault) begin
            fault_d   = 1'b1;
            ctrl_d    = FAULT;
            counter_d = 32'd0;
         end else begin
            state_d = nextState[3:0];
            tick_d  = 1'b1;
         end
      end

      if (cfg_we) begin
         if (ctrl_q == RUN) begin
            cfgErr_d = 1'b1;
         end else begin
            case (cfg_sel)
               SEL_UCODE: ucodeWe = 1'b1;
               SEL_DROM1: begin
                  if (cfg_addr > 4'd3) cfgErr_d = 1'b1;
                  else                 drom1We  = 1'b1;
               end
               SEL_DROM2: begin
                  if (cfg_addr > 4'd3) cfgErr_d = 1'b1;
                  else                 drom2We  = 1'b1;
               end
               default: begin
                  if (cfg_addr != 4'd0) begin
                     cfgErr_d = 1'b1;
                  end else if (ctrl_q == FAULT) begin
                     fault_d = 1'b0;
                     ctrl_d  = IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Controller, state, prescaler and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= IDLE;
         state_q   <= 4'd0;
         counter_q <= 32'd0;
         fault_q   <= 1'b0;
         tick_q    <= 1'b0;
         cfgErr_q  <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         state_q   <= state_d;
         counter_q <= counter_d;
         fault_q   <= fault_d;
         tick_q    <= tick_d;
         cfgErr_q  <= cfgErr_d;
      end
   end

   // Table storage; reset restores the fixed power-on image.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            ucode_q[i] <= defaultUcode(4'(i));
         end
         for (int i = 0; i < 4; i++) begin
            drom1_q[i] <= defaultDrom1(2'(i));
            drom2_q[i] <= defaultDrom2(2'(i));
         end
      end else begin
         if (ucodeWe) ucode_q[cfg_addr]      <= cfg_data[2:0];
         if (drom1We) drom1_q[cfg_addr[1:0]] <= cfg_data;
         if (drom2We) drom2_q[cfg_addr[1:0]] <= cfg_data;
      end
   end

   assign state   = state_q;
   assign tick    = tick_q;
   assign halted  = (ctrl_q != RUN);
   assign fault   = fault_q;
   assign cfg_err = cfgErr_q;

endmodule

// File: doc/ucode_seq_ctrl.md
Name: ucode_seq_ctrl

Overview:
- Run/step controller for the board's microcoded LED state machine.
- Holds a writable microcode store and two dispatch tables, and generates the step tick from a prescaler.
- Synchronises the pushbutton that latches the 2-bit switch input.
- Sequences the state register under run/step/halt control and reports faults; drives the LED state output directly.

Parameters:
- TICK_MAX, 100000000, clk cycles per microcode step in RUN (bench uses 4)
- NSTATES, 13, number of legal states (max 16)
- JUMP_TGT, 7, target state of opcode JUMP

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn  in  1  raw pushbutton; rising edge latches y
- y  in  2  raw switch input
- run  in  1  level; 1 = free-run at tick rate
- step  in  1  one-cycle pulse; single step while not running
- cfg_we  in  1  table write strobe
- cfg_sel  in  2  0 = microcode, 1 = DROM1, 2 = DROM2, 3 = reserved
- cfg_addr  in  4  table index
- cfg_data  in  4  write data (microcode uses [2:0])
- state  out  4  current state, drives led[3:0]
- tick  out  1  one-cycle pulse on each state advance
- halted  out  1  1 when not in RUN
- fault  out  1  sticky fault flag
- cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (async, rst_n=0):
  - state=0, counter=0, inp=0, controller=IDLE.
  - tick=0, halted=1, fault=0, cfg_err=0.
  - Tables load their defaults; these values are fixed.
  - Microcode[0..12] = 0,0,0,1,3,3,3,0,0,0,2,4,4; entries 13..15 = 4.
  - DROM1 = 4,5,6,6. DROM2 = 11,12,12,12.
- Input sync:
  - btn and y pass through 2-FF synchronisers.
  - On a synchronised btn rising edge, inp <= synced y.
  - Latency: a btn edge is visible in inp 3 clk after it is sampled.
  - Continuously held btn produces no further captures.
- Opcodes (microcode[state]):
  - 0 NEXT: state+1; wraps to 0 when state == NSTATES-1.
  - 1 DISP1: DROM1[inp].
  - 2 DISP2: DROM2[inp].
  - 3 JUMP: JUMP_TGT.
  - 4 HOME: 0.
  - 5..7 illegal.
- Advance rule: an advance computes the next state from the opcode; tick pulses in the same cycle the state register updates.
- Fault conditions:
  - An illegal opcode, or a computed next state >= NSTATES, is a fault.
  - On fault: state holds, fault <= 1, controller -> FAULT, no tick.
- Controller states:
  - IDLE: halted=1, counter held at 0.
    - run=1 -> RUN.
    - step pulse -> one advance in the next cycle, remain IDLE.
  - RUN: halted=0, counter increments each clk.
    - When counter == TICK_MAX-1: advance, counter <= 0.
    - run=0 -> IDLE, counter cleared, no advance that cycle.
    - step is ignored in RUN.
  - FAULT: halted=1, no advances.
    - Leaves only via rst_n, or via a cfg write with cfg_sel=3, cfg_addr=0 (clear).
    - Clear sets fault=0 and moves to IDLE; state is kept.
- Config writes:
  - Accepted only when halted=1; the table entry updates the next clk.
  - cfg_we while in RUN, or to cfg_sel=1/2 with cfg_addr > 3: rejected, cfg_err pulses for 1 cycle, tables unchanged.
  - cfg_sel=3 with any cfg_addr != 0: rejected, cfg_err pulses for 1 cycle.
  - Out-of-range dispatch data is stored as written; it faults only when used.
- Simultaneous events:
  - inp capture and advance in the same cycle: the advance uses the old inp.
  - cfg write and step in the same cycle: the step uses the old table contents.
  - run rising in the same cycle as step: go to RUN, step is ignored.
- Arithmetic: counter is 32-bit unsigned, compared for equality only. NEXT wraps only at NSTATES-1, never by 4-bit overflow.

Decomposition:
- Package ucode_pkg holds:
  - Opcode constants OP_NEXT..OP_HOME.
  - Controller state enum IDLE/RUN/FAULT.
  - cfg_sel constants.
  - Default table contents.
- One sub-module, btn_sync: 2-FF synchroniser plus rising-edge detector for btn, with y capture producing inp.

Test Plan:
- Reset then run=1, TICK_MAX=4, btn never pressed:
  - states 0,1,2,3,4,7,8,9,10,11,0,… with one tick every 4 clk.
  - state 3 -> 4 via DROM1[0]; state 11 -> 0 via HOME.
- Halted at state 3, y=2, btn pulse, then step:
  - inp=2 three clk after the edge.
  - step moves to state 6; the next step moves to 7.
- Halted at state 10, y=0, btn pulse, then step -> state 11. With y=3 latched instead -> state 12.
- Write DROM1[0]=14 while halted, set state to 3, step:
  - state stays 3, fault=1, halted=1, no tick.
  - step and run are then ignored.
  - cfg_sel=3 addr=0 clears fault; controller returns to IDLE.
- cfg_we during RUN:
  - cfg_err pulses once, table unchanged.
  - cfg_sel=1 addr=5 while halted also pulses cfg_err.
- Drop run=0 when counter=2:
  - no advance, halted=1 next clk.
  - run=1 again: the first advance occurs 4 clk later.
- Assert rst_n=0 mid-RUN: all outputs and tables return to reset values immediately, without waiting for clk.
